// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_op_sequencer_if : command/ALU/response bundle for alu_op_sequencer   |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
interface alu_op_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3
);
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [DATA_W-1:0] cmd_a_i;
  logic [DATA_W-1:0] cmd_b_i;
  logic [OP_W-1:0]   cmd_op_i;
  logic              cmd_sweep_i;
  logic [DATA_W-1:0] alu_a_o;
  logic [DATA_W-1:0] alu_b_o;
  logic [OP_W-1:0]   alu_op_o;
  logic [DATA_W-1:0] alu_res_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_res_o;
  logic [OP_W-1:0]   rsp_op_o;
  logic              rsp_last_o;
  logic              busy_o;

  // Environment side: issues commands, hosts the ALU, consumes responses.
  modport master (
    output cmd_valid_i, cmd_a_i, cmd_b_i, cmd_op_i, cmd_sweep_i, alu_res_i, rsp_ready_i,
    input  cmd_ready_o, alu_a_o, alu_b_o, alu_op_o, rsp_valid_o, rsp_res_o, rsp_op_o,
           rsp_last_o, busy_o
  );

  modport slave (
    input  cmd_valid_i, cmd_a_i, cmd_b_i, cmd_op_i, cmd_sweep_i, alu_res_i, rsp_ready_i,
    output cmd_ready_o, alu_a_o, alu_b_o, alu_op_o, rsp_valid_o, rsp_res_o, rsp_op_o,
           rsp_last_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_op_sequencer : drives a combinational ALU, waits SETTLE cycles,      |
// | returns the sampled result; optional sweep over every opcode. Rev 1.0    |
// +--------------------------------------------------------------------------+
module alu_op_sequencer #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3,
  parameter int SETTLE = 1
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  alu_op_sequencer_if.slave bus
);

  localparam int                  c_CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [c_CNT_W-1:0]  c_CNT_LOAD = c_CNT_W'(SETTLE - 1);
  localparam logic [OP_W-1:0]     c_OP_LAST  = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_sweep;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [OP_W-1:0]     r_alu_op;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_res;
  logic [OP_W-1:0]     r_rsp_op;
  logic                r_rsp_last;
  logic                r_busy;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_sweep     <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_res   <= '0;
      r_rsp_op    <= '0;
      r_rsp_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid_i) begin
            r_alu_a  <= bus.cmd_a_i;
            r_alu_b  <= bus.cmd_b_i;
            r_alu_op <= bus.cmd_sweep_i ? '0 : bus.cmd_op_i;
            r_sweep  <= bus.cmd_sweep_i;
            r_cnt    <= c_CNT_LOAD;
            r_busy   <= 1'b1;
            r_state  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            r_rsp_res   <= bus.alu_res_i;
            r_rsp_op    <= r_alu_op;
            r_rsp_last  <= !r_sweep || (r_alu_op == c_OP_LAST);
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          // Everything holds until the consumer takes the response.
          if (bus.rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            if (r_rsp_last) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_alu_op <= r_alu_op + 1'b1;
              r_cnt    <= c_CNT_LOAD;
              r_state  <= ST_SETTLE;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready_o = (r_state == ST_IDLE);
  assign bus.alu_a_o     = r_alu_a;
  assign bus.alu_b_o     = r_alu_b;
  assign bus.alu_op_o    = r_alu_op;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_res_o   = r_rsp_res;
  assign bus.rsp_op_o    = r_rsp_op;
  assign bus.rsp_last_o  = r_rsp_last;
  assign bus.busy_o      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_op_sequencer : bench for alu_op_sequencer, SETTLE=1 and SETTLE=3  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int nassert = 0;
  int nfail   = 0;

  // Bench-side stand-in for the Simple_ALU.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a << b[1:0];
      3'd3:    return a >> b[1:0];
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return a ^ b;
      default: return (a == b) ? 8'd1 : 8'd0;
    endcase
  endfunction

  alu_op_sequencer_if #(.DATA_W(8), .OP_W(3)) if1 ();
  alu_op_sequencer_if #(.DATA_W(8), .OP_W(3)) if3 ();

  alu_op_sequencer #(.DATA_W(8), .OP_W(3), .SETTLE(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));
  alu_op_sequencer #(.DATA_W(8), .OP_W(3), .SETTLE(3)) dut3 (.clk_i(clk), .rst_i(rst), .bus(if3));

  // sel chooses which DUT the shared stimulus and observation refer to.
  logic       sel = 1'b0;
  logic       cmd_valid = 1'b0, cmd_sweep = 1'b0, rsp_ready = 1'b1;
  logic [7:0] cmd_a = '0, cmd_b = '0;
  logic [2:0] cmd_op = '0;

  assign if1.cmd_valid_i = cmd_valid & ~sel;
  assign if3.cmd_valid_i = cmd_valid & sel;
  assign if1.rsp_ready_i = rsp_ready | sel;
  assign if3.rsp_ready_i = rsp_ready | ~sel;
  assign if1.cmd_a_i = cmd_a;     assign if3.cmd_a_i = cmd_a;
  assign if1.cmd_b_i = cmd_b;     assign if3.cmd_b_i = cmd_b;
  assign if1.cmd_op_i = cmd_op;   assign if3.cmd_op_i = cmd_op;
  assign if1.cmd_sweep_i = cmd_sweep;
  assign if3.cmd_sweep_i = cmd_sweep;
  assign if1.alu_res_i = alu_f(if1.alu_a_o, if1.alu_b_o, if1.alu_op_o);
  assign if3.alu_res_i = alu_f(if3.alu_a_o, if3.alu_b_o, if3.alu_op_o);

  logic       o_ready, o_rv, o_last, o_busy;
  logic [7:0] o_res, o_a, o_b;
  logic [2:0] o_op, o_aop;
  assign o_ready = sel ? if3.cmd_ready_o : if1.cmd_ready_o;
  assign o_rv    = sel ? if3.rsp_valid_o : if1.rsp_valid_o;
  assign o_last  = sel ? if3.rsp_last_o  : if1.rsp_last_o;
  assign o_busy  = sel ? if3.busy_o      : if1.busy_o;
  assign o_res   = sel ? if3.rsp_res_o   : if1.rsp_res_o;
  assign o_op    = sel ? if3.rsp_op_o    : if1.rsp_op_o;
  assign o_a     = sel ? if3.alu_a_o     : if1.alu_a_o;
  assign o_b     = sel ? if3.alu_b_o     : if1.alu_b_o;
  assign o_aop   = sel ? if3.alu_op_o    : if1.alu_op_o;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_alu_a"}, o_a, 0);
    check({tag, "_alu_b"}, o_b, 0);
    check({tag, "_alu_op"}, o_aop, 0);
    check({tag, "_rsp_valid"}, o_rv, 0);
    check({tag, "_rsp_res"}, o_res, 0);
    check({tag, "_rsp_op"}, o_op, 0);
    check({tag, "_rsp_last"}, o_last, 0);
    check({tag, "_busy"}, o_busy, 0);
  endtask

  // Issue one command from IDLE and consume its responses against the
  // expected list; optional stall on one opcode, optional reset on one opcode.
  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic sweep, input int stall_op, input int stall_len,
                         input int rst_op);
    int         settle = sel ? 3 : 1;
    int         lat;
    logic [2:0] exp_ops[$];
    logic [7:0] held_res;
    if (sweep) for (int k = 0; k < 8; k++) exp_ops.push_back(3'(k));
    else       exp_ops.push_back(op);

    cmd_a = a; cmd_b = b; cmd_op = op; cmd_sweep = sweep; cmd_valid = 1'b1;
    check("cmd_ready_idle", o_ready, 1);
    step();
    cmd_valid = 1'b0;
    cmd_op = ~op;
    lat = 1;
    check("alu_a_c1", o_a, a);
    check("alu_b_c1", o_b, b);
    check("cmd_ready_busy", o_ready, 0);
    check("busy_c1", o_busy, 1);

    for (int k = 0; k < exp_ops.size(); k++) begin
      logic [2:0] cur = exp_ops[k];
      logic       exp_last = !sweep || (k == exp_ops.size() - 1);
      while (o_rv !== 1'b1 && lat <= 40) begin
        check("alu_op_settle", o_aop, cur);
        check("alu_ab_settle", {o_a, o_b}, {a, b});
        check("cmd_ready_settle", o_ready, 0);
        step();
        lat++;
      end
      if (lat > 40) begin
        check("rsp_timeout", 0, 1);
        return;
      end
      check("rsp_latency", lat, settle + 1);
      check("rsp_op", o_op, cur);
      check("rsp_res", o_res, alu_f(a, b, cur));
      check("rsp_last", o_last, exp_last);
      check("alu_op_at_rsp", o_aop, cur);

      if (int'(cur) == rst_op) begin
        rsp_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        check_reset_outputs("midrst");
        check("midrst_cmd_ready", o_ready, 1);
        for (int i = 0; i < 3; i++) begin
          step();
          check("midrst_no_rsp", o_rv, 0);
        end
        return;
      end

      if (int'(cur) == stall_op) begin
        held_res = o_res;
        rsp_ready = 1'b0;
        for (int i = 0; i < stall_len; i++) begin
          step();
          check("stall_valid", o_rv, 1);
          check("stall_res", o_res, held_res);
          check("stall_op", o_op, cur);
          check("stall_alu_op", o_aop, cur);
        end
        rsp_ready = 1'b1;
      end
      step();
      lat = 1;
    end
    check("done_valid", o_rv, 0);
    check("done_busy", o_busy, 0);
    check("done_ready", o_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    logic [2:0] rop;
    rst = 1'b1;
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();
    check("reset_cmd_ready", o_ready, 1);
    sel = 1'b1;
    #1;
    check_reset_outputs("reset3");
    check("reset3_cmd_ready", o_ready, 1);
    sel = 1'b0;
    #1;

    run_cmd(8'h3C, 8'h0F, 3'b010, 1'b0, -1, 0, -1);
    run_cmd(8'h3C, 8'h0F, 3'd5, 1'b1, -1, 0, -1);
    run_cmd(8'hAA, 8'hAA, 3'b111, 1'b0, -1, 0, -1);
    run_cmd(8'h01, 8'h07, 3'b010, 1'b0, -1, 0, -1);
    run_cmd(8'h3C, 8'h0F, 3'd6, 1'b1, 3, 5, -1);
    run_cmd(8'($urandom), 8'($urandom), 3'd2, 1'b1, -1, 0, 3);
    run_cmd(8'h3C, 8'h0F, 3'd7, 1'b1, -1, 0, -1);
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rop = 3'($urandom);
      if (i == 2) rb = ra;
      run_cmd(ra, rb, rop, 1'b0, -1, 0, -1);
    end
    run_cmd(8'($urandom), 8'($urandom), 3'($urandom), 1'b1, int'($urandom_range(0, 7)),
            int'($urandom_range(1, 4)), -1);

    sel = 1'b1;
    step();
    run_cmd(8'h5A, 8'h13, 3'd1, 1'b0, -1, 0, -1);
    run_cmd(8'($urandom), 8'($urandom), 3'd0, 1'b1, 6, 2, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Initiator-side driver for the team's combinational Simple_ALU (8-bit a/b, 3-bit op, 8-bit result). Accepts operand/opcode commands over a valid/ready handshake, drives the ALU inputs, and waits a programmable settle time. It then samples the ALU result and returns it over a valid/ready response channel. A sweep mode issues every opcode 0..7 for one operand pair, giving a hardware replacement for the bench-side op sweep.

Parameters:
DATA_W, 8, operand/result width; must match the ALU
OP_W, 3, opcode width; sweep covers 0 .. 2**OP_W-1
SETTLE, 1, cycles the ALU inputs are held stable before sampling the result; legal range >= 1

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous active-high reset
cmd_valid_i  input  1  command present
cmd_ready_o  output  1  sequencer can accept a command
cmd_a_i  input  DATA_W  operand a
cmd_b_i  input  DATA_W  operand b
cmd_op_i  input  OP_W  opcode; ignored when cmd_sweep_i=1
cmd_sweep_i  input  1  1 = issue all opcodes 0..2**OP_W-1 in ascending order
alu_a_o  output  DATA_W  to ALU a_i
alu_b_o  output  DATA_W  to ALU b_i
alu_op_o  output  OP_W  to ALU op_i
alu_res_i  input  DATA_W  from ALU alu_o
rsp_valid_o  output  1  response present
rsp_ready_i  input  1  consumer accepts response
rsp_res_o  output  DATA_W  sampled ALU result
rsp_op_o  output  OP_W  opcode that produced rsp_res_o
rsp_last_o  output  1  final response of the current command
busy_o  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst_i=1 at a rising edge): state=IDLE, settle counter=0, and all registered outputs 0 (alu_a_o, alu_b_o, alu_op_o, rsp_valid_o, rsp_res_o, rsp_op_o, rsp_last_o, busy_o). cmd_ready_o=1 from the first cycle after reset. Reset has priority over every other event. A reset mid-command drops the in-flight command and any pending response; no partial response is produced.
- States:
  - IDLE: cmd_ready_o=1. On cmd_valid_i&cmd_ready_o: register a and b into alu_a_o/alu_b_o; alu_op_o := cmd_sweep_i ? 0 : cmd_op_i; latch the sweep flag; load the counter with SETTLE-1; go to SETTLE.
  - SETTLE: alu_* held stable. Counter decrements each cycle. In the cycle the counter is 0: at the edge, rsp_res_o := alu_res_i, rsp_op_o := alu_op_o, rsp_last_o := (!sweep) | (alu_op_o == all-ones), rsp_valid_o := 1; go to RESP.
  - RESP: rsp_* and alu_* held stable while rsp_valid_o&!rsp_ready_i. On handshake: rsp_valid_o := 0.
    - If rsp_last_o: go to IDLE.
    - Else: alu_op_o := alu_op_o+1, reload the counter with SETTLE-1, go to SETTLE.
- cmd_ready_o is combinational from state only (IDLE); it never depends on cmd_valid_i. Commands presented while busy stay pending and are not consumed.
- Latency: handshake in cycle c0, ALU inputs valid from c1, sample at end of c(SETTLE), rsp_valid_o high from c(SETTLE+1). With SETTLE=1, rsp_valid_o rises 2 cycles after the command handshake. In sweep, each next response follows the previous response handshake by SETTLE+1 cycles.
- Earliest new command: the cycle after the final response handshake (IDLE reached). There is no same-cycle overlap.
- alu_a_o/alu_b_o/alu_op_o keep their last values in IDLE; they are not cleared.
- Opcode increment never wraps: the sweep terminates at all-ones with rsp_last_o=1.
- A sweep command yields exactly 2**OP_W responses, with rsp_op_o 0,1,...,7 in order for defaults.
- rsp_valid_o, once high, stays high with stable data until accepted (AXI-style; no retraction).

Test Plan:
1. Single op, SETTLE=1: a=3C b=0F op=010 (SLL) -> alu_op_o=010 from c1; rsp_valid_o high at c2; rsp_res_o=ALU model result; rsp_op_o=010; rsp_last_o=1; cmd_ready_o=0 during c1..response.
2. Sweep: a=3C b=0F sweep=1, rsp_ready_i=1 -> 8 responses with rsp_op_o 0..7, each matching the model. rsp_last_o=1 only on op 7; returns to IDLE and busy_o=0 afterwards.
3. Equality/boundary: a=AA b=AA op=111 single, then a=01 b=07 op=010 issued back to back -> responses match the model. The second command is accepted exactly one cycle after the first response handshake.
4. Backpressure: rsp_ready_i low 5 cycles during sweep op 3 -> rsp_res_o, rsp_op_o=3 and alu_op_o stay unchanged; no response is lost or duplicated; op 4 follows SETTLE+1 cycles after the handshake.
5. Reset mid-sweep: assert rst_i while rsp_op_o=3 pending -> next cycle all outputs 0, cmd_ready_o=1. A new sweep starts at op 0.
6. SETTLE=3 build: single command -> rsp_valid_o rises 4 cycles after the handshake; alu_* stable across all 3 settle cycles.
